// File: rtl/uart_rx.sv
// uart_rx: UART receiver (start, 8 data bits LSB first, stop) with a one-byte valid/ready output buffer.
// Define UART_RX_PARITY_EN to receive an even-parity bit after D7 and check it.
module uart_rx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BIT_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       parity_error
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BIT_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_e;

    // Receiver state; readable hierarchically as state_q for checkers.
    state_e           state_q, state_d;
    logic [1:0]       sync_q;
    logic             rxd_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             stop_ok_q, stop_ok_d;
    logic             done_q, done_d;
    logic             bit_tick;

    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             fe_q, fe_d;
    logic             ov_q, ov_d;
    logic             consume;

`ifdef UART_RX_PARITY_EN
    logic             par_bit_q, par_bit_d;
    logic             pe_q, pe_d;
`endif

    assign rxd_s    = sync_q[1];
    assign bit_tick = (cnt_q == CNT_BIT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        stop_ok_d = stop_ok_q;
        done_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d = par_bit_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rxd_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                // Mid-start-bit check: a line already back high was a glitch.
                if (cnt_q == CNT_HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rxd_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_tick) begin
                    cnt_d     = '0;
                    shift_d   = {rxd_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_tick) begin
                    cnt_d     = '0;
                    par_bit_d = rxd_s;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                // The verdict is applied to the output buffer one edge later.
                if (bit_tick) begin
                    cnt_d     = '0;
                    stop_ok_d = rxd_s;
                    done_d    = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshake: a byte transfers on every rising edge with rx_valid && rx_ready;
    // rx_data is held constant for as long as rx_valid is high.
    assign consume = rx_valid_q && rx_ready;

    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        fe_d       = 1'b0;
        ov_d       = 1'b0;
`ifdef UART_RX_PARITY_EN
        pe_d       = 1'b0;
`endif
        if (consume) begin
            rx_valid_d = 1'b0;
        end
        if (done_q) begin
            if (!stop_ok_q) begin
                fe_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if ((^shift_q) != par_bit_q) begin
                pe_d = 1'b1;
`endif
            end else if (rx_valid_q && !rx_ready) begin
                ov_d = 1'b1;
            end else begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b11;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            stop_ok_q  <= 1'b0;
            done_q     <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            fe_q       <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], rxd};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            stop_ok_q  <= stop_ok_d;
            done_q     <= done_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            fe_q       <= fe_d;
            ov_q       <= ov_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit_q <= 1'b0;
            pe_q      <= 1'b0;
        end else begin
            par_bit_q <= par_bit_d;
            pe_q      <= pe_d;
        end
    end

    assign parity_error = pe_q;
`else
    assign parity_error = 1'b0;
`endif

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign framing_error = fe_q;
    assign overrun       = ov_q;

endmodule
